// File: rtl/time_mgr_if.sv
// Heartbeat upstream channel: valid/ack handshake carrying time snapshots to the PC.
interface time_mgr_if #(
    parameter int unsigned Ntime = 40
) ();
    logic             HB_up_v;
    logic [Ntime-1:0] HB_up_d;
    logic             HB_up_a;

    modport master (output HB_up_v, output HB_up_d, input HB_up_a);
    modport slave  (input HB_up_v, input HB_up_d, output HB_up_a);
endinterface

// File: rtl/time_mgr.sv
// time_mgr: divides clk into units of unit_len cycles, keeps time_elapsed,
// stalls the downstream stream path while the PC's send time is in the future.
// Optional heartbeat reporting of time_elapsed is built when TIME_MGR_HB_EN is defined.
module time_mgr #(
    parameter int unsigned Nunit = 16,
    parameter int unsigned Ntime = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_time_i,
    input  logic [Nunit-1:0] unit_len_i,
    input  logic [Ntime-1:0] pc_time_elapsed_i,
    output logic [Ntime-1:0] time_elapsed_o,
    output logic             unit_tick_o,
    output logic             stall_dn_o,
    time_mgr_if.master       hb_up
);

    logic [Nunit-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [Ntime-1:0] time_q, time_d;
    logic             tick_q, tick_d;
    logic             stall_q, stall_d;
    logic             boundary_c;

    // ">=" lets a mid-unit shrink of unit_len close the unit on the next cycle
    assign boundary_c = (unit_len_i != '0) && (cycle_cnt_q >= (unit_len_i - Nunit'(1)));

    // Unit counter, time advance and stall decision against the time being registered
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        time_d      = time_q;
        tick_d      = 1'b0;
        if (reset_time_i) begin
            cycle_cnt_d = '0;
            time_d      = '0;
        end else if (boundary_c) begin
            cycle_cnt_d = '0;
            time_d      = time_q + Ntime'(1);
            tick_d      = 1'b1;
        end else if (unit_len_i != '0) begin
            cycle_cnt_d = cycle_cnt_q + Nunit'(1);
        end
        stall_d = (pc_time_elapsed_i > time_d);
    end

    // Time-base state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            time_q      <= '0;
            tick_q      <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            time_q      <= time_d;
            tick_q      <= tick_d;
            stall_q     <= stall_d;
        end
    end

    assign time_elapsed_o = time_q;
    assign unit_tick_o    = tick_q;
    assign stall_dn_o     = stall_q;

`ifdef TIME_MGR_HB_EN
    logic             hb_v_q, hb_v_d;
    logic [Ntime-1:0] hb_d_q, hb_d_d;
    logic             hb_pend_q, hb_pend_d;
    logic             xfer_c;

    assign xfer_c = hb_v_q && hb_up.HB_up_a;

    // Heartbeat offer: fresh tick wins, otherwise coalesce into a single pending reload
    always_comb begin
        hb_v_d    = hb_v_q;
        hb_d_d    = hb_d_q;
        hb_pend_d = hb_pend_q;
        if (xfer_c) begin
            if (hb_pend_q) begin
                hb_v_d    = 1'b1;
                hb_d_d    = time_q;
                hb_pend_d = 1'b0;
            end else begin
                hb_v_d = 1'b0;
            end
        end
        if (tick_d) begin
            if (!hb_v_q || xfer_c) begin
                hb_v_d    = 1'b1;
                hb_d_d    = time_d;
                hb_pend_d = 1'b0;
            end else begin
                hb_pend_d = 1'b1;
            end
        end
        // An in-flight beat survives reset_time; only the coalesced request is dropped
        if (reset_time_i) begin
            hb_pend_d = 1'b0;
        end
    end

    // Heartbeat state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_v_q    <= 1'b0;
            hb_d_q    <= '0;
            hb_pend_q <= 1'b0;
        end else begin
            hb_v_q    <= hb_v_d;
            hb_d_q    <= hb_d_d;
            hb_pend_q <= hb_pend_d;
        end
    end

    assign hb_up.HB_up_v = hb_v_q;
    assign hb_up.HB_up_d = hb_d_q;
`else
    logic unused_hb_a;

    assign unused_hb_a   = hb_up.HB_up_a;
    assign hb_up.HB_up_v = 1'b0;
    assign hb_up.HB_up_d = '0;
`endif

endmodule

// File: tb/tb_time_mgr.sv
// Directed bench for time_mgr: a 40-bit instance for the main behaviour and a
// 4-bit instance running unit_len=1 alongside it to exercise the time wrap.
module tb_time_mgr;

    logic        clk;
    logic        reset;

    logic        rt_a;
    logic [15:0] len_a;
    logic [39:0] pc_a;
    logic [39:0] te_a;
    logic        tick_a;
    logic        stall_a;

    logic        rt_b;
    logic [15:0] len_b;
    logic [3:0]  pc_b;
    logic [3:0]  te_b;
    logic        tick_b;
    logic        stall_b;

    int n_chk;
    int n_pass;

    time_mgr_if #(.Ntime(40)) hb_a ();
    time_mgr_if #(.Ntime(4))  hb_b ();

    time_mgr #(.Nunit(16), .Ntime(40)) u_dut_a (
        .clk               (clk),
        .reset             (reset),
        .reset_time_i      (rt_a),
        .unit_len_i        (len_a),
        .pc_time_elapsed_i (pc_a),
        .time_elapsed_o    (te_a),
        .unit_tick_o       (tick_a),
        .stall_dn_o        (stall_a),
        .hb_up             (hb_a)
    );

    time_mgr #(.Nunit(16), .Ntime(4)) u_dut_b (
        .clk               (clk),
        .reset             (reset),
        .reset_time_i      (rt_b),
        .unit_len_i        (len_b),
        .pc_time_elapsed_i (pc_b),
        .time_elapsed_o    (te_b),
        .unit_tick_o       (tick_b),
        .stall_dn_o        (stall_b),
        .hb_up             (hb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        rt_a   = 1'b0;
        len_a  = 16'd4;
        pc_a   = '0;
        hb_a.HB_up_a = 1'b1;
        rt_b   = 1'b0;
        len_b  = 16'd1;
        pc_b   = '0;
        hb_b.HB_up_a = 1'b1;

        step(2);
        check("rst_time", 64'(te_a), 64'd0);
        check("rst_tick", 64'(tick_a), 64'd0);
        check("rst_stall", 64'(stall_a), 64'd0);
        check("rst_hb_v", 64'(hb_a.HB_up_v), 64'd0);
        check("rst_hb_d", 64'(hb_a.HB_up_d), 64'd0);
        reset = 1'b0;

        // unit_len=4 for 20 cycles; instance b wraps at cycle 16
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("u4_tick", 64'(tick_a), 64'((k % 4) == 0));
            check("u4_time", 64'(te_a), 64'(k / 4));
            check("u4_stall", 64'(stall_a), 64'd0);
`ifdef TIME_MGR_HB_EN
            if (k == 4) begin
                check("u4_hb_v", 64'(hb_a.HB_up_v), 64'd1);
                check("u4_hb_d", 64'(hb_a.HB_up_d), 64'd1);
            end
`endif
            if (k == 15) begin
                check("wrap_pre", 64'(te_b), 64'd15);
            end
            if (k == 16) begin
                check("wrap_time", 64'(te_b), 64'd0);
                check("wrap_tick", 64'(tick_b), 64'd1);
            end
        end

        // unit_len 10 -> 3 with cycle_cnt=7, then unit_len=0 freezes time
        rt_a  = 1'b1;
        len_a = 16'd10;
        step(1);
        rt_a  = 1'b0;
        step(7);
        check("shr_pre_time", 64'(te_a), 64'd0);
        check("shr_pre_tick", 64'(tick_a), 64'd0);
        len_a = 16'd3;
        step(1);
        check("shr_tick1", 64'(tick_a), 64'd1);
        check("shr_time1", 64'(te_a), 64'd1);
        step(2);
        check("shr_gap", 64'(tick_a), 64'd0);
        step(1);
        check("shr_tick2", 64'(tick_a), 64'd1);
        check("shr_time2", 64'(te_a), 64'd2);
        len_a = 16'd0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("frz_tick", 64'(tick_a), 64'd0);
            check("frz_time", 64'(te_a), 64'd2);
        end

        // stall while PC time (3) is ahead, unit_len=2
        len_a = 16'd2;
        pc_a  = 40'd3;
        rt_a  = 1'b1;
        step(1);
        rt_a  = 1'b0;
        check("stl_start", 64'(stall_a), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check("stl_time", 64'(te_a), 64'(k / 2));
            check("stl_stall", 64'(stall_a), 64'((k / 2) < 3));
        end
        pc_a = '0;
        step(1);
        check("stl_pc0", 64'(stall_a), 64'd0);

        // heartbeat coalescing and reset_time with a beat in flight
        hb_a.HB_up_a = 1'b1;
        rt_a = 1'b1;
        step(2);
        rt_a = 1'b0;
        hb_a.HB_up_a = 1'b0;
        step(2);
        check("hb_time1", 64'(te_a), 64'd1);
`ifdef TIME_MGR_HB_EN
        check("hb_v1", 64'(hb_a.HB_up_v), 64'd1);
        check("hb_d1", 64'(hb_a.HB_up_d), 64'd1);
        step(6);
        check("hb_time4", 64'(te_a), 64'd4);
        check("hb_hold_v", 64'(hb_a.HB_up_v), 64'd1);
        check("hb_hold_d", 64'(hb_a.HB_up_d), 64'd1);
        hb_a.HB_up_a = 1'b1;
        step(1);
        check("hb_reload_v", 64'(hb_a.HB_up_v), 64'd1);
        check("hb_reload_d", 64'(hb_a.HB_up_d), 64'd4);
        hb_a.HB_up_a = 1'b0;
        step(4);
        check("hb_time6", 64'(te_a), 64'd6);
        check("hb_d4_hold", 64'(hb_a.HB_up_d), 64'd4);
        hb_a.HB_up_a = 1'b1;
        step(1);
        check("hb_tickxfer_t", 64'(te_a), 64'd7);
        check("hb_tickxfer_d", 64'(hb_a.HB_up_d), 64'd7);
        check("hb_tickxfer_v", 64'(hb_a.HB_up_v), 64'd1);
        hb_a.HB_up_a = 1'b0;
        step(3);
        check("hb_time8", 64'(te_a), 64'd8);
        rt_a = 1'b1;
        step(1);
        check("rt_time", 64'(te_a), 64'd0);
        check("rt_tick", 64'(tick_a), 64'd0);
        check("rt_hb_v", 64'(hb_a.HB_up_v), 64'd1);
        check("rt_hb_d", 64'(hb_a.HB_up_d), 64'd7);
        rt_a  = 1'b0;
        len_a = 16'd0;
        step(2);
        check("rt_held_d", 64'(hb_a.HB_up_d), 64'd7);
        hb_a.HB_up_a = 1'b1;
        step(1);
        check("rt_pend_clr", 64'(hb_a.HB_up_v), 64'd0);
`else
        check("nohb_v", 64'(hb_a.HB_up_v), 64'd0);
        check("nohb_d", 64'(hb_a.HB_up_d), 64'd0);
        len_a = 16'd0;
        step(2);
        hb_a.HB_up_a = 1'b1;
`endif

        // async reset mid-unit / mid-handshake clears everything at once
        hb_a.HB_up_a = 1'b0;
        len_a = 16'd1;
        pc_a  = 40'd9;
        step(1);
        check("ar_pre_tick", 64'(tick_a), 64'd1);
        check("ar_pre_stall", 64'(stall_a), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_time", 64'(te_a), 64'd0);
        check("ar_tick", 64'(tick_a), 64'd0);
        check("ar_stall", 64'(stall_a), 64'd0);
        check("ar_hb_v", 64'(hb_a.HB_up_v), 64'd0);
        step(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
